// File: rtl/coder_pkg.sv
// Shared definitions for the turbo-coder receive path: FSM states, trellis taps, widths.
package coder_pkg;

    localparam int unsigned SIZE_W   = 16;
    localparam int unsigned SUM_W    = SIZE_W + 1;
    localparam int unsigned TAIL_CYC = 3;
    localparam int unsigned RSC_W    = 3;

    // Tap masks over r = {r2, r1, r0}: g0 = 1+D^2+D^3 (feedback), g1 = 1+D+D^3 (parity)
    localparam logic [RSC_W-1:0] FB_TAPS = 3'b110;
    localparam logic [RSC_W-1:0] FF_TAPS = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_TAIL = 2'd2,
        ST_DONE = 2'd3
    } rx_state_e;

    function automatic logic [SIZE_W-1:0] sat_add(input logic [SIZE_W-1:0] v,
                                                   input logic [1:0]        inc);
        logic [SUM_W-1:0] s;
        s = {1'b0, v} + SUM_W'(inc);
        return s[SUM_W-1] ? {SIZE_W{1'b1}} : s[SIZE_W-1:0];
    endfunction

endpackage

// File: rtl/rsc_ref_enc.sv
// Local constituent-1 RSC used to predict zk (data) and xk/zk (termination) of the incoming stream.
module rsc_ref_enc
    import coder_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic adv_i,
    input  logic term_i,
    input  logic x_i,
    output logic exp_x_c,
    output logic exp_z_c
);

    logic [RSC_W-1:0] r_q, r_d;
    logic             fb;
    logic             a;

    always_comb begin
        fb      = ^(r_q & FB_TAPS);
        a       = term_i ? 1'b0 : (x_i ^ fb);
        exp_x_c = fb;
        exp_z_c = a ^ (^(r_q & FF_TAPS));
        r_d     = r_q;
        if (clr_i) begin
            r_d = '0;
        end else if (adv_i) begin
            r_d = {r_q[RSC_W-2:0], a};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

endmodule

// File: rtl/coded_stream_rx.sv
// Turbo-coder stream receiver: packs xk into words, checks zk and the encoder-1 termination.
module coded_stream_rx
    import coder_pkg::*;
#(
    parameter int unsigned OUT_W = 8,
    parameter int unsigned MAX_K = 8192
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SIZE_W-1:0] size_in,
    input  logic              wreq_size,
    input  logic              in_valid,
    input  logic              xk_in,
    input  logic              zk_in,
    input  logic              zk_prime_in,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              block_done,
    output logic [SIZE_W-1:0] err_count,
    output logic [SIZE_W-1:0] p2_ones,
    output logic              overflow
);

    localparam int unsigned IDX_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int unsigned FIFO_D = 2;

    typedef struct packed {
        logic             last;
        logic [OUT_W-1:0] data;
    } word_t;

    rx_state_e         state_q, state_d;
    logic [SIZE_W-1:0] k_q, k_d;
    logic [SIZE_W-1:0] bit_q, bit_d;
    logic [IDX_W-1:0]  pidx_q, pidx_d;
    logic [OUT_W-1:0]  pack_q, pack_d;
    logic [SIZE_W-1:0] err_q, err_d;
    logic [SIZE_W-1:0] p2_q, p2_d;
    logic              ovf_q, ovf_d;
    word_t             mem_q [FIFO_D];
    word_t             mem_d [FIFO_D];
    logic              wr_q, wr_d;
    logic              rd_q, rd_d;
    logic [1:0]        cnt_q, cnt_d;
    word_t             head_q, head_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              rsc_clr, rsc_adv, rsc_term;
    logic              exp_x_c, exp_z_c;
    logic              blk_start, last_bit, push, pop, full, wr_en, p2_inc;
    logic [1:0]        err_inc;
    logic [OUT_W-1:0]  pack_nxt;
    word_t             push_word;

    rsc_ref_enc u_rsc (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (rsc_clr),
        .adv_i   (rsc_adv),
        .term_i  (rsc_term),
        .x_i     (xk_in),
        .exp_x_c (exp_x_c),
        .exp_z_c (exp_z_c)
    );

    // Next-state: block FSM, counters, pack register and the fall-through FIFO
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        bit_d     = bit_q;
        pidx_d    = pidx_q;
        pack_d    = pack_q;
        mem_d     = mem_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        rsc_clr   = 1'b0;
        rsc_adv   = 1'b0;
        rsc_term  = 1'b0;
        blk_start = 1'b0;
        push      = 1'b0;
        push_word = '0;
        err_inc   = 2'd0;
        p2_inc    = 1'b0;
        last_bit  = (bit_q == (k_q - SIZE_W'(1)));
        pack_nxt  = pack_q | (OUT_W'(xk_in) << pidx_q);

        case (state_q)
            ST_IDLE: begin
                if (wreq_size && (size_in != '0) && (size_in <= SIZE_W'(MAX_K))) begin
                    k_d       = size_in;
                    bit_d     = '0;
                    pidx_d    = '0;
                    pack_d    = '0;
                    rsc_clr   = 1'b1;
                    blk_start = 1'b1;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (in_valid) begin
                    rsc_adv = 1'b1;
                    err_inc = {1'b0, zk_in ^ exp_z_c};
                    p2_inc  = zk_prime_in;
                    if ((pidx_q == IDX_W'(OUT_W - 1)) || last_bit) begin
                        push      = 1'b1;
                        push_word = '{last: last_bit, data: pack_nxt};
                        pack_d    = '0;
                        pidx_d    = '0;
                    end else begin
                        pack_d = pack_nxt;
                        pidx_d = pidx_q + IDX_W'(1);
                    end
                    if (last_bit) begin
                        bit_d   = '0;
                        state_d = ST_TAIL;
                    end else begin
                        bit_d = bit_q + SIZE_W'(1);
                    end
                end
            end
            ST_TAIL: begin
                if (in_valid) begin
                    rsc_adv  = 1'b1;
                    rsc_term = 1'b1;
                    err_inc  = 2'(xk_in ^ exp_x_c) + 2'(zk_in ^ exp_z_c);
                    if (bit_q == SIZE_W'(TAIL_CYC - 1)) begin
                        bit_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        bit_d = bit_q + SIZE_W'(1);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // A full FIFO still accepts a push when the head leaves in the same cycle
        pop   = valid_q && out_ready;
        full  = (cnt_q == 2'(FIFO_D));
        wr_en = push && (!full || pop);
        if (wr_en) begin
            mem_d[wr_q] = push_word;
            wr_d        = ~wr_q;
        end
        if (pop) begin
            rd_d = ~rd_q;
        end
        cnt_d   = cnt_q + 2'(wr_en) - 2'(pop);
        valid_d = (cnt_d != 2'd0);
        head_d  = valid_d ? mem_d[rd_d] : '0;

        err_d  = blk_start ? '0 : sat_add(err_q, err_inc);
        p2_d   = blk_start ? '0 : sat_add(p2_q, {1'b0, p2_inc});
        ovf_d  = blk_start ? 1'b0 : (ovf_q | (push & ~wr_en));
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            bit_q   <= '0;
            pidx_q  <= '0;
            pack_q  <= '0;
            err_q   <= '0;
            p2_q    <= '0;
            ovf_q   <= 1'b0;
            mem_q   <= '{default: '0};
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            cnt_q   <= 2'd0;
            head_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            bit_q   <= bit_d;
            pidx_q  <= pidx_d;
            pack_q  <= pack_d;
            err_q   <= err_d;
            p2_q    <= p2_d;
            ovf_q   <= ovf_d;
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out_data   = head_q.data;
    assign out_last   = head_q.last;
    assign out_valid  = valid_q;
    assign busy       = busy_q;
    assign block_done = done_q;
    assign err_count  = err_q;
    assign p2_ones    = p2_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_coded_stream_rx.sv
// Scoreboard bench for coded_stream_rx: expected words queued at drive time, popped on each transfer.
module tb_coded_stream_rx;

    logic        clk;
    logic        reset;
    logic [15:0] size_in;
    logic        wreq_size;
    logic        in_valid;
    logic        xk_in;
    logic        zk_in;
    logic        zk_prime_in;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        block_done;
    logic [15:0] err_count;
    logic [15:0] p2_ones;
    logic        overflow;

    int          n_tests;
    int          n_fail;
    int          xfers;
    bit          rand_ready;
    logic [8:0]  exp_q[$];
    logic        hold_v;
    logic [8:0]  hold_w;

    coded_stream_rx #(.OUT_W(8), .MAX_K(8192)) dut (
        .clk         (clk),
        .reset       (reset),
        .size_in     (size_in),
        .wreq_size   (wreq_size),
        .in_valid    (in_valid),
        .xk_in       (xk_in),
        .zk_in       (zk_in),
        .zk_prime_in (zk_prime_in),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .busy        (busy),
        .block_done  (block_done),
        .err_count   (err_count),
        .p2_ones     (p2_ones),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: transfers are popped against the scoreboard, held words must not change
    always @(negedge clk) begin
        if (reset) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v && out_valid)
                check("hold_stable", {23'd0, out_last, out_data}, {23'd0, hold_w});
            if (out_valid && out_ready) begin
                xfers++;
                check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0)
                    check("word", {23'd0, out_last, out_data}, {23'd0, exp_q.pop_front()});
            end
            hold_v = out_valid && !out_ready;
            hold_w = {out_last, out_data};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic x, input logic z, input logic zp);
        in_valid    = 1'b1;
        xk_in       = x;
        zk_in       = z;
        zk_prime_in = zp;
        step();
        in_valid = 1'b0;
    endtask

    task automatic start_block(input int k);
        size_in   = 16'(k);
        wreq_size = 1'b1;
        step();
        wreq_size = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
    endtask

    // Fixed 4-bit block from literal bit vectors (bit i = triplet i, tail in bits 6:4)
    task automatic run_fixed(input string tag, input logic [6:0] xs, input logic [6:0] zs,
                             input int exp_err);
        exp_q.push_back(9'h101);
        start_block(4);
        for (int i = 0; i < 7; i++) send(xs[i], zs[i], 1'b0);
        check({tag, "_done"}, 32'(block_done), 32'd1);
        check({tag, "_err"}, 32'(err_count), 32'(exp_err));
        step();
        check({tag, "_done_pulse"}, 32'(block_done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    // Model-driven block: correct parity and termination from a reference RSC
    task automatic run_block(input int k, input bit rnd, input int gap_mode,
                             input int max_words, input int wreq_at);
        logic [2:0] r;
        logic [7:0] w;
        logic       x, z, zp, a;
        int         widx, nwords, p2, gap;
        r = '0; w = '0; widx = 0; nwords = 0; p2 = 0;
        start_block(k);
        for (int i = 0; i < k + 3; i++) begin
            if (i < k) begin
                x  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                zp = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                a  = x ^ r[1] ^ r[2];
            end else begin
                x  = r[1] ^ r[2];
                zp = 1'($urandom_range(0, 1));
                a  = 1'b0;
            end
            z = a ^ r[0] ^ r[2];
            r = {r[1], r[0], a};
            if (i < k) begin
                if (zp) p2++;
                w[widx] = x;
                widx++;
                if (widx == 8 || i == k - 1) begin
                    if (nwords < max_words) exp_q.push_back({(i == k - 1), w});
                    nwords++;
                    w    = '0;
                    widx = 0;
                end
            end
            if (i == wreq_at) begin
                size_in   = 16'd8;
                wreq_size = 1'b1;
            end
            send(x, z, zp);
            wreq_size = 1'b0;
            if (i < k + 2) begin
                if (i == k + 1)
                    check("tail_not_done", 32'(block_done), 32'd0);
                gap = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
                repeat (gap) step();
            end
        end
        check("blk_done", 32'(block_done), 32'd1);
        check("blk_err", 32'(err_count), 32'd0);
        check("blk_p2", 32'(p2_ones), 32'(p2));
        step();
        check("blk_done_pulse", 32'(block_done), 32'd0);
        check("blk_idle", 32'(busy), 32'd0);
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 40 && (exp_q.size() != 0 || out_valid); c++) step();
        check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_fifo_empty"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int  x0;
        bit  seen_done;
        n_tests = 0; n_fail = 0; xfers = 0; rand_ready = 1'b0;
        hold_v = 1'b0; hold_w = '0;
        reset = 1'b1; size_in = '0; wreq_size = 1'b0; in_valid = 1'b0;
        xk_in = 1'b0; zk_in = 1'b0; zk_prime_in = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs",
              {out_valid, out_last, out_data, busy, block_done, overflow, err_count[9:0], p2_ones[9:0]}, 32'd0);
        reset = 1'b0;
        step();

        // Reset mid-DATA with a word parked in the FIFO and non-zero counters
        out_ready = 1'b0;
        start_block(16);
        for (int i = 0; i < 9; i++) send(1'b0, 1'b1, 1'b1);
        check("t1_err_pre", 32'(err_count), 32'd9);
        check("t1_p2_pre", 32'(p2_ones), 32'd9);
        check("t1_valid_pre", 32'(out_valid), 32'd1);
        reset = 1'b1;
        step();
        step();
        check("t1_rst_outputs",
              {out_valid, out_last, out_data, busy, block_done, overflow, err_count[9:0], p2_ones[9:0]}, 32'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            seen_done |= block_done;
        end
        check("t1_no_done", 32'(seen_done), 32'd0);
        check("t1_fifo_empty", 32'(out_valid), 32'd0);
        check("t1_idle", 32'(busy), 32'd0);

        // Fixed K=4 vectors: clean, then one data-parity and one tail-x error
        run_fixed("t2", 7'b1010001, 7'b1111111, 0);
        drain("t2");
        run_fixed("t3", 7'b1110001, 7'b1111011, 2);
        drain("t3");

        // K=16 all-zero with alternating valid gaps
        run_block(16, 1'b0, 1, 99, -1);
        drain("t4");

        // Random data, partial last word, random gaps and back-pressure
        rand_ready = 1'b1;
        run_block(13, 1'b1, 2, 99, -1);
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        drain("rnd");

        // Single-bit block
        run_block(1, 1'b1, 0, 99, -1);
        drain("k1");

        // K=32 with the sink stalled: only the first two words survive
        out_ready = 1'b0;
        run_block(32, 1'b1, 0, 2, -1);
        check("t5_overflow", 32'(overflow), 32'd1);
        check("t5_held", 32'(out_valid), 32'd1);
        x0 = xfers;
        out_ready = 1'b1;
        drain("t5");
        check("t5_xfers", 32'(xfers - x0), 32'd2);

        // Size write during DATA is ignored; bad sizes in IDLE are ignored
        run_block(16, 1'b1, 0, 99, 3);
        drain("t6");
        check("t6_ovf_cleared", 32'(overflow), 32'd0);
        size_in = 16'd0;
        wreq_size = 1'b1;
        step();
        wreq_size = 1'b0;
        check("t6_size0_busy", 32'(busy), 32'd0);
        step();
        check("t6_size0_busy2", 32'(busy), 32'd0);
        size_in = 16'd8193;
        wreq_size = 1'b1;
        step();
        wreq_size = 1'b0;
        check("t6_sizebig_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
